rscl_branch_resolve: RTL and testbench

- Execute-stage consumer of the branch comparator's `taken` output.
- Computes the actual next PC for conditional branches, JAL and JALR, and compares it against the fetch prediction.
- On a mispredict, issues a held redirect to fetch over a valid/ready handshake and toggles an epoch bit so that wrong-path instructions are dropped.
- Also produces the link value (pc+4) for writeback and flags misaligned targets.

---
 rtl/rscl_branch_resolve.sv | 196 +++++++++++++++++++
 tb/tb_rscl_branch_resolve.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rscl_branch_resolve.sv
// ---------------------------------------------------------------------------
// rscl_branch_resolve
//
// Execute-stage branch/jump resolution. Takes the comparator's taken bit and
// works out the real next PC for conditional branches, JAL and JALR. It
// compares that PC with the fetch prediction. On a mispredict it raises a
// held redirect to fetch (valid/ready) and flips the epoch bit, so that
// wrong-path ops still in flight get dropped. It also returns the link value
// (pc+4) for writeback and reports misaligned targets as an exception.
// All results are registered one cycle after the op fires.
//
// Optional feature macro: RSCL_BRANCH_STATS_EN
//   When defined, adds two saturating counters, stat_branches and
//   stat_mispredicts, each CNT_W bits wide.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  op handshake; in_ready = !redir_valid || redir_ready
//   in_epoch           epoch tag of the op (stale ops are swallowed)
//   in_is_jal/jalr     jump kind; in_taken is ignored for jumps
//   in_taken           comparator result for conditional branches
//   in_pc, in_rs1,
//   in_imm             operands (imm already sign-extended)
//   in_pred_taken,
//   in_pred_target     what fetch assumed
//   res_valid          one-cycle pulse: live op resolved without fault
//   res_link           pc+4 for rd writeback
//   res_is_jump        res_link must be written (JAL/JALR)
//   exc_valid          one-cycle pulse: misaligned target
//   exc_pc, exc_tval   faulting op PC and bad target
//   redir_valid/ready  redirect request to fetch, held until accepted
//   redir_pc           corrected fetch PC
//   cur_epoch          current epoch, tagged onto new fetches
//   stat_branches,
//   stat_mispredicts   (RSCL_BRANCH_STATS_EN only) live ops / redirects
// ---------------------------------------------------------------------------
module rscl_branch_resolve #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_epoch,
    input  logic        in_is_jal,
    input  logic        in_is_jalr,
    input  logic        in_taken,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_imm,
    input  logic        in_pred_taken,
    input  logic [31:0] in_pred_target,
    output logic        res_valid,
    output logic [31:0] res_link,
    output logic        res_is_jump,
    output logic        exc_valid,
    output logic [31:0] exc_pc,
    output logic [31:0] exc_tval,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_pc,
    output logic        cur_epoch
`ifdef RSCL_BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
`endif
);

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // ------------------------------------------------------------------
    // Stage p0: combinational resolution of the presented op
    // ------------------------------------------------------------------
    logic        w_fire;
    logic        w_live;
    logic [31:0] w_pc4;
    logic [31:0] w_jalr_sum;
    logic [31:0] w_target;
    logic [31:0] w_actual;
    logic [31:0] w_predicted;
    logic        w_mispredict;
    logic        w_misaligned;
    logic        w_redirect;

    logic        r_epoch;
    logic        r_redir_valid_p1;
    logic [31:0] r_redir_pc_p1;
    logic        r_res_valid_p1;
    logic [31:0] r_res_link_p1;
    logic        r_res_is_jump_p1;
    logic        r_exc_valid_p1;
    logic [31:0] r_exc_pc_p1;
    logic [31:0] r_exc_tval_p1;

    // A pending redirect only blocks new ops while fetch has not taken it.
    // If fetch takes it this cycle, the slot frees up on the same edge.
    assign in_ready     = !r_redir_valid_p1 || redir_ready;
    assign w_fire       = in_valid && in_ready;
    // Compare with the registered epoch. After a mispredict it has already
    // flipped, so ops fetched down the wrong path show up as stale here.
    assign w_live       = w_fire && (in_epoch == r_epoch);

    assign w_pc4        = in_pc + 32'd4;
    assign w_jalr_sum   = in_rs1 + in_imm;
    assign w_target     = in_is_jalr ? {w_jalr_sum[31:1], 1'b0} : (in_pc + in_imm);
    assign w_actual     = (in_is_jal || in_is_jalr || in_taken) ? w_target : w_pc4;
    assign w_predicted  = in_pred_taken ? in_pred_target : w_pc4;
    assign w_mispredict = (w_actual != w_predicted);
    // The fall-through path is never a fault, even if the target would be.
    assign w_misaligned = (w_actual != w_pc4) && (w_actual[1:0] != 2'b00);
    assign w_redirect   = w_live && w_mispredict && !w_misaligned;

    // ------------------------------------------------------------------
    // Stage p1: registered results, redirect hold and epoch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid_p1   <= 1'b0;
            r_res_link_p1    <= 32'd0;
            r_res_is_jump_p1 <= 1'b0;
            r_exc_valid_p1   <= 1'b0;
            r_exc_pc_p1      <= 32'd0;
            r_exc_tval_p1    <= 32'd0;
        end else begin
            r_res_valid_p1 <= w_live && !w_misaligned;
            r_exc_valid_p1 <= w_live && w_misaligned;
            if (w_live && !w_misaligned) begin
                r_res_link_p1    <= w_pc4;
                r_res_is_jump_p1 <= in_is_jal || in_is_jalr;
            end
            if (w_live && w_misaligned) begin
                r_exc_pc_p1   <= in_pc;
                r_exc_tval_p1 <= w_actual;
            end
        end
    end

    // A new redirect takes priority over retiring the old one. When both
    // happen on the same edge, the old one has been accepted, and valid
    // stays high with the new PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redir_valid_p1 <= 1'b0;
            r_redir_pc_p1    <= 32'd0;
            r_epoch          <= 1'b0;
        end else begin
            if (w_redirect) begin
                r_redir_valid_p1 <= 1'b1;
                r_redir_pc_p1    <= w_actual;
                r_epoch          <= ~r_epoch;
            end else if (r_redir_valid_p1 && redir_ready) begin
                r_redir_valid_p1 <= 1'b0;
            end
        end
    end

`ifdef RSCL_BRANCH_STATS_EN
    logic [CNT_W-1:0] r_stat_branches;
    logic [CNT_W-1:0] r_stat_mispredicts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_live) begin
                r_stat_branches <= sat_inc(r_stat_branches);
            end
            if (w_redirect) begin
                r_stat_mispredicts <= sat_inc(r_stat_mispredicts);
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

    assign res_valid   = r_res_valid_p1;
    assign res_link    = r_res_link_p1;
    assign res_is_jump = r_res_is_jump_p1;
    assign exc_valid   = r_exc_valid_p1;
    assign exc_pc      = r_exc_pc_p1;
    assign exc_tval    = r_exc_tval_p1;
    assign redir_valid = r_redir_valid_p1;
    assign redir_pc    = r_redir_pc_p1;
    assign cur_epoch   = r_epoch;

endmodule

// File: tb/tb_rscl_branch_resolve.sv
module tb_rscl_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_epoch;
    logic        in_is_jal;
    logic        in_is_jalr;
    logic        in_taken;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_imm;
    logic        in_pred_taken;
    logic [31:0] in_pred_target;
    logic        res_valid;
    logic [31:0] res_link;
    logic        res_is_jump;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        cur_epoch;
`ifdef RSCL_BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    rscl_branch_resolve #(.CNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_epoch       (in_epoch),
        .in_is_jal      (in_is_jal),
        .in_is_jalr     (in_is_jalr),
        .in_taken       (in_taken),
        .in_pc          (in_pc),
        .in_rs1         (in_rs1),
        .in_imm         (in_imm),
        .in_pred_taken  (in_pred_taken),
        .in_pred_target (in_pred_target),
        .res_valid      (res_valid),
        .res_link       (res_link),
        .res_is_jump    (res_is_jump),
        .exc_valid      (exc_valid),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .redir_valid    (redir_valid),
        .redir_ready    (redir_ready),
        .redir_pc       (redir_pc),
        .cur_epoch      (cur_epoch)
`ifdef RSCL_BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] link; logic jump; } res_t;
    typedef struct { logic [31:0] pc; logic [31:0] tval; } exc_t;
    typedef struct { logic [31:0] pc; logic epoch; } redir_t;

    res_t   res_q[$];
    exc_t   exc_q[$];
    redir_t redir_q[$];

    int checks;
    int failures;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: output pulse seen, expected none queued at %0t", nm, $time);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic        prev_v;
    logic        prev_acc;
    logic [31:0] prev_pc;
    initial begin
        prev_v = 1'b0; prev_acc = 1'b0; prev_pc = 32'd0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v   = 1'b0;
            prev_acc = 1'b0;
        end else begin
            if (res_valid) begin
                if (res_q.size() == 0) unexpected("res_valid");
                else begin
                    res_t e;
                    e = res_q.pop_front();
                    chk32("res_link", res_link, e.link);
                    chk1("res_is_jump", res_is_jump, e.jump);
                end
            end
            if (exc_valid) begin
                if (exc_q.size() == 0) unexpected("exc_valid");
                else begin
                    exc_t e;
                    e = exc_q.pop_front();
                    chk32("exc_pc", exc_pc, e.pc);
                    chk32("exc_tval", exc_tval, e.tval);
                end
            end
            if (redir_valid) begin
                if (!prev_v || prev_acc) begin
                    if (redir_q.size() == 0) unexpected("redir_valid");
                    else begin
                        redir_t e;
                        e = redir_q.pop_front();
                        chk32("redir_pc", redir_pc, e.pc);
                        chk1("cur_epoch_after_redir", cur_epoch, e.epoch);
                    end
                end else begin
                    chk32("redir_pc_hold", redir_pc, prev_pc);
                end
                chk1("in_ready_vs_redir_ready", in_ready, redir_ready);
            end
            prev_v   = redir_valid;
            prev_acc = redir_valid && redir_ready;
            prev_pc  = redir_pc;
        end
    end

    // Drive one op; expectations are queued once the op is known to fire.
    task automatic send(input logic ep, input logic jal, input logic jalr, input logic tk,
                        input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptgt,
                        input logic e_res, input logic [31:0] e_link, input logic e_jump,
                        input logic e_exc, input logic [31:0] e_tval,
                        input logic e_redir, input logic [31:0] e_rpc, input logic e_rep);
        int n;
        in_valid = 1'b1; in_epoch = ep; in_is_jal = jal; in_is_jalr = jalr; in_taken = tk;
        in_pc = pc; in_rs1 = rs1; in_imm = imm; in_pred_taken = pt; in_pred_target = ptgt;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=%0b expected 1 within 20 cycles", in_ready);
        end else begin
            if (e_res) res_q.push_back('{link: e_link, jump: e_jump});
            if (e_exc) exc_q.push_back('{pc: pc, tval: e_tval});
            if (e_redir) redir_q.push_back('{pc: e_rpc, epoch: e_rep});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_epoch = 1'b0; in_is_jal = 1'b0; in_is_jalr = 1'b0;
        in_taken = 1'b0; in_pc = 32'd0; in_rs1 = 32'd0; in_imm = 32'd0;
        in_pred_taken = 1'b0; in_pred_target = 32'd0; redir_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk1("rst_res_valid", res_valid, 1'b0);
        chk1("rst_exc_valid", exc_valid, 1'b0);
        chk1("rst_redir_valid", redir_valid, 1'b0);
        chk32("rst_redir_pc", redir_pc, 32'd0);
        chk32("rst_res_link", res_link, 32'd0);
        chk32("rst_exc_pc", exc_pc, 32'd0);
        chk32("rst_exc_tval", exc_tval, 32'd0);
        chk1("rst_cur_epoch", cur_epoch, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // BEQ taken, correctly predicted
        send(0, 0, 0, 1, 32'h100, 32'h0, 32'h20, 1, 32'h120,
             1, 32'h104, 0, 0, 32'h0, 0, 32'h0, 0);
        idle(2);
        chk1("beq_ok_epoch", cur_epoch, 1'b0);
        chk1("beq_ok_no_redir", redir_valid, 1'b0);

        // Same BEQ mispredicted (pred not-taken), redirect held by fetch
        redir_ready = 1'b0;
        send(0, 0, 0, 1, 32'h100, 32'h0, 32'h20, 0, 32'h0,
             1, 32'h104, 0, 0, 32'h0, 1, 32'h120, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("hold_in_ready", in_ready, 1'b0);
            chk1("hold_redir_valid", redir_valid, 1'b1);
            chk32("hold_redir_pc", redir_pc, 32'h120);
        end
        @(posedge clk);
        #1;
        redir_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk1("redir_cleared", redir_valid, 1'b0);
        chk1("epoch_after_mispredict", cur_epoch, 1'b1);
        @(posedge clk);
        #1;

        // Stale op (epoch 0) must vanish; then a live not-taken branch
        send(0, 0, 0, 1, 32'h100, 32'h0, 32'h20, 0, 32'h0,
             0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0);
        send(1, 0, 0, 0, 32'h300, 32'h0, 32'h10, 0, 32'h0,
             1, 32'h304, 0, 0, 32'h0, 0, 32'h0, 0);
        idle(1);
        chk1("stale_epoch_kept", cur_epoch, 1'b1);

        // JALR: (0x1001 + 4) & ~1 = 0x1004
        send(1, 0, 1, 0, 32'h400, 32'h1001, 32'h4, 0, 32'h0,
             1, 32'h404, 1, 0, 32'h0, 1, 32'h1004, 0);
        idle(2);

        // JAL to 0x206: misaligned, exception only
        send(0, 1, 0, 0, 32'h200, 32'h0, 32'h6, 0, 32'h0,
             0, 32'h0, 0, 1, 32'h206, 0, 32'h0, 0);
        idle(2);
        chk1("jal_misaligned_epoch", cur_epoch, 1'b0);
        chk1("jal_misaligned_no_redir", redir_valid, 1'b0);

        // Back-to-back mispredicts; second fires as the first is accepted
        send(0, 0, 0, 1, 32'h500, 32'h0, 32'h40, 0, 32'h0,
             1, 32'h504, 0, 0, 32'h0, 1, 32'h540, 1);
        send(1, 1, 0, 0, 32'h600, 32'h0, 32'h100, 0, 32'h0,
             1, 32'h604, 1, 0, 32'h0, 1, 32'h700, 0);
        idle(2);
        chk1("b2b_redir_cleared", redir_valid, 1'b0);
        chk1("b2b_epoch", cur_epoch, 1'b0);

        // Correctly predicted JAL never redirects
        send(0, 1, 0, 0, 32'h800, 32'h0, 32'h10, 1, 32'h810,
             1, 32'h804, 1, 0, 32'h0, 0, 32'h0, 0);
        idle(2);
        chk1("jal_ok_no_redir", redir_valid, 1'b0);

        // Reset while a redirect is pending
        redir_ready = 1'b0;
        send(0, 0, 0, 1, 32'h900, 32'h0, 32'h8, 0, 32'h0,
             1, 32'h904, 0, 0, 32'h0, 1, 32'h908, 1);
        @(posedge clk);
        #2;
        chk1("pre_rst_redir_valid", redir_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("midrst_redir_valid", redir_valid, 1'b0);
        chk1("midrst_cur_epoch", cur_epoch, 1'b0);
        chk1("midrst_in_ready", in_ready, 1'b1);
`ifdef RSCL_BRANCH_STATS_EN
        chk32("midrst_stat_branches", stat_branches, 32'd0);
        chk32("midrst_stat_mispredicts", stat_mispredicts, 32'd0);
`endif
        redir_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        chk32("res_q_drained", res_q.size(), 32'd0);
        chk32("exc_q_drained", exc_q.size(), 32'd0);
        chk32("redir_q_drained", redir_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
